// File: rtl/btn_rdr_pkg.sv
// Shared types and constants for the pushbutton reader: FSM states, pending-counter
// width and the legal debounce tick range.
package btn_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } state_e;

    localparam int PC_W         = 4;
    localparam int DB_TICKS_MIN = 1;
    localparam int DB_TICKS_MAX = 15;

endpackage

// File: rtl/btn_rdr_if.sv
// Button bank bundle: raw inputs from the board plus the conditioned outputs.
// The reader is the slave side; whoever drives the raw pins is the master.
interface btn_rdr_if #(
    parameter int N = 4
);
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] tog;

    modport master (output raw, input lvl, rise, fall, tog);
    modport slave  (input raw, output lvl, rise, fall, tog);
endinterface

// File: rtl/btn_db_ch.sv
// One debounced channel: 2-flop synchronizer, optional inversion, tick-driven
// STABLE/PEND filter and registered level/edge/toggle outputs.
module btn_db_ch
    import btn_pkg::*;
#(
    parameter int DB_TICKS = 4,
    parameter bit INV      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tck,
    input  logic raw_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o,
    output logic tog_o
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(DB_TICKS - 1);

    logic            sync1_q, sync2_q;
    logic            s;
    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            lvl_q, lvl_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            tog_q, tog_d;
    logic            commit;

    assign s = sync2_q ^ INV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE;
            pc_q    <= '0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            pc_q    <= pc_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            tog_q   <= tog_d;
        end
    end

    // A change must be seen on DB_TICKS consecutive ticks; any agreeing tick cancels it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        commit  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (tck && (s != lvl_q)) begin
                    if (DB_TICKS == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_d = PEND;
                        pc_d    = PC_W'(1);
                    end
                end
            end
            PEND: begin
                if (tck) begin
                    if (s == lvl_q) begin
                        state_d = STABLE;
                        pc_d    = '0;
                    end else if (pc_q == PC_LAST) begin
                        commit  = 1'b1;
                        state_d = STABLE;
                        pc_d    = '0;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                state_d = STABLE;
                pc_d    = '0;
            end
        endcase

        lvl_d  = lvl_q ^ commit;
        rise_d = commit & ~lvl_q;
        fall_d = commit & lvl_q;
        tog_d  = tog_q ^ (commit & ~lvl_q);
    end

    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign tog_o  = tog_q;

endmodule

// File: rtl/btn_rdr.sv
// Pushbutton/switch bank reader: one shared sample prescaler feeding N
// independent debounce channels.
module btn_rdr
    import btn_pkg::*;
#(
    parameter int N         = 4,
    parameter int TCK_WIDTH = 16,
    parameter int DB_TICKS  = 4,
    parameter bit INV       = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    btn_rdr_if.slave  bus
);

    logic [TCK_WIDTH-1:0] cnt_q;
    logic                 tck;
    logic [N-1:0]         lvl_w, rise_w, fall_w, tog_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TCK_WIDTH'(1);
        end
    end

    // All-ones lasts one cycle per wrap, so every channel samples on the same edge.
    assign tck = &cnt_q;

    for (genvar i = 0; i < N; i++) begin : g_ch
        btn_db_ch #(
            .DB_TICKS (DB_TICKS),
            .INV      (INV)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .tck    (tck),
            .raw_i  (bus.raw[i]),
            .lvl_o  (lvl_w[i]),
            .rise_o (rise_w[i]),
            .fall_o (fall_w[i]),
            .tog_o  (tog_w[i])
        );
    end

    assign bus.lvl  = lvl_w;
    assign bus.rise = rise_w;
    assign bus.fall = fall_w;
    assign bus.tog  = tog_w;

endmodule

// File: tb/tb_btn_rdr.sv
// Directed bench for btn_rdr with a 4-cycle tick and 3-tick debounce: presses,
// bounce, glitch, release, reset while pending and simultaneous commits.
module tb_btn_rdr;

    logic clk;
    logic rst_n;
    int   testsRun  = 0;
    int   failCount = 0;
    int   riseCnt [4];
    int   fallCnt [4];
    logic [3:0] firstRise;
    logic [3:0] rawV;
    int   lat;

    btn_rdr_if #(.N(4)) bus ();

    btn_rdr #(
        .N         (4),
        .TCK_WIDTH (2),
        .DB_TICKS  (3),
        .INV       (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and the first nonzero rise vector, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            riseCnt[i] += int'(bus.rise[i]);
            fallCnt[i] += int'(bus.fall[i]);
        end
        if (firstRise == 4'b0 && bus.rise != 4'b0) firstRise = bus.rise;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v);
        bus.raw = v;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 4; i++) begin
            riseCnt[i] = 0;
            fallCnt[i] = 0;
        end
        firstRise = 4'b0;
    endtask

    // Returns the number of posedges until lvl[ch] equals want, or 99 on timeout.
    task automatic waitLevel(input int ch, input logic want, output int k);
        k = 99;
        for (int c = 1; c <= 20; c++) begin
            cycles(1);
            if (bus.lvl[ch] == want) begin
                k = c;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rawV  = 4'b0000;
        applyStimulus(rawV);
        clearCounts();
        cycles(3);
        rst_n = 1'b1;

        checkOutput("reset_lvl",  32'(bus.lvl),  32'h0);
        checkOutput("reset_rise", 32'(bus.rise), 32'h0);
        checkOutput("reset_fall", 32'(bus.fall), 32'h0);
        checkOutput("reset_tog",  32'(bus.tog),  32'h0);

        cycles(5);
        clearCounts();
        rawV[0] = 1'b1;
        applyStimulus(rawV);
        waitLevel(0, 1'b1, lat);
        checkOutput("press_latency", 32'(lat >= 10 && lat <= 14), 32'h1);
        cycles(3);
        checkOutput("press_lvl",  32'(bus.lvl[0]), 32'h1);
        checkOutput("press_tog",  32'(bus.tog[0]), 32'h1);
        checkOutput("press_rise", 32'(riseCnt[0]), 32'd1);
        checkOutput("press_fall", 32'(fallCnt[0]), 32'd0);

        clearCounts();
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) rawV[1] = ~rawV[1];
            applyStimulus(rawV);
            cycles(1);
        end
        rawV[1] = 1'b1;
        applyStimulus(rawV);
        cycles(20);
        checkOutput("bounce_rise", 32'(riseCnt[1]), 32'd1);
        checkOutput("bounce_fall", 32'(fallCnt[1]), 32'd0);
        checkOutput("bounce_lvl",  32'(bus.lvl[1]), 32'h1);
        checkOutput("bounce_tog",  32'(bus.tog[1]), 32'h1);

        clearCounts();
        rawV[2] = 1'b1;
        applyStimulus(rawV);
        cycles(5);
        rawV[2] = 1'b0;
        applyStimulus(rawV);
        cycles(20);
        checkOutput("glitch_lvl",  32'(bus.lvl[2]), 32'h0);
        checkOutput("glitch_rise", 32'(riseCnt[2]), 32'd0);
        checkOutput("glitch_tog",  32'(bus.tog[2]), 32'h0);

        clearCounts();
        rawV[0] = 1'b0;
        applyStimulus(rawV);
        waitLevel(0, 1'b0, lat);
        checkOutput("release_latency", 32'(lat >= 10 && lat <= 14), 32'h1);
        cycles(3);
        checkOutput("release_fall", 32'(fallCnt[0]), 32'd1);
        checkOutput("release_rise", 32'(riseCnt[0]), 32'd0);
        checkOutput("release_tog",  32'(bus.tog[0]), 32'h1);

        clearCounts();
        rawV[0] = 1'b1;
        applyStimulus(rawV);
        cycles(20);
        checkOutput("repress_rise", 32'(riseCnt[0]), 32'd1);
        checkOutput("repress_lvl",  32'(bus.lvl[0]), 32'h1);
        checkOutput("repress_tog",  32'(bus.tog[0]), 32'h0);

        rawV[3] = 1'b1;
        applyStimulus(rawV);
        cycles(6);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_lvl",  32'(bus.lvl),  32'h0);
        checkOutput("rstmid_tog",  32'(bus.tog),  32'h0);
        checkOutput("rstmid_rise", 32'(bus.rise), 32'h0);
        cycles(2);
        clearCounts();
        rst_n = 1'b1;
        waitLevel(3, 1'b1, lat);
        checkOutput("rstmid_latency", 32'(lat >= 10 && lat <= 14), 32'h1);
        cycles(3);
        checkOutput("rstmid_rise3", 32'(riseCnt[3]), 32'd1);
        checkOutput("rstmid_fall3", 32'(fallCnt[3]), 32'd0);

        rawV = 4'b0000;
        applyStimulus(rawV);
        cycles(20);
        checkOutput("simul_idle_lvl", 32'(bus.lvl), 32'h0);
        clearCounts();
        rawV = 4'b0011;
        applyStimulus(rawV);
        cycles(20);
        checkOutput("simul_rise_vec", 32'(firstRise), 32'h3);
        checkOutput("simul_lvl",      32'(bus.lvl),   32'h3);
        checkOutput("simul_rise0",    32'(riseCnt[0]), 32'd1);
        checkOutput("simul_rise1",    32'(riseCnt[1]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
